// File: rtl/uart_tx_mem_if.sv
// Register bus between the CPU and the memory-mapped UART transmitter.
// The CPU drives the write strobe and data; the peripheral returns the status/data word.
interface uart_tx_mem_if;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (output mem_wen, output mem_wdata, input  mem_rdata);
    modport slave  (input  mem_wen, input  mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_tx_mem.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a transmit buffer.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_mem #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_mem_if.slave bus,
    output logic         o_Tx_Serial,
    output logic         o_Tx_Active,
    output logic         o_Tx_Done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       last_byte;
    logic [7:0]       head_byte;
    logic             overrun;
    logic             done_flag;
    logic             buf_full;
    logic             buf_empty;
    logic             start_req;
    logic             clear_req;
    logic             push;
    logic             pop;
    logic             unused_bits;

    assign start_req   = bus.mem_wen & bus.mem_wdata[31];
    assign clear_req   = bus.mem_wen & bus.mem_wdata[30];
    assign push        = start_req & ~buf_full;
    assign pop         = ~buf_empty & ((state == S_IDLE) |
                         ((state == S_STOP) & (baud_cnt == CNT_LAST)));
    assign unused_bits = ^bus.mem_wdata[29:8];

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign buf_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign buf_empty = (count == '0);
    assign head_byte = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_byte;
    logic       unused_depth;

    assign buf_full     = hold_valid;
    assign buf_empty    = ~hold_valid;
    assign head_byte    = hold_byte;
    assign unused_depth = ^FIFO_DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_byte  <= bus.mem_wdata[7:0];
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Sticky flags: a set event in the same cycle as CLEAR takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_byte <= '0;
            overrun   <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            if (push) last_byte <= bus.mem_wdata[7:0];
            if (start_req & buf_full) overrun <= 1'b1;
            else if (clear_req)       overrun <= 1'b0;
            if (o_Tx_Done)            done_flag <= 1'b1;
            else if (clear_req)       done_flag <= 1'b0;
        end
    end

    assign bus.mem_rdata = {o_Tx_Active | ~buf_empty, buf_full, overrun, done_flag,
                            20'd0, last_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= (state == S_STOP) && (baud_cnt == CNT_PRE);
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg   <= head_byte;
                        state       <= S_START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt    <= '0;
                        bit_idx     <= '0;
                        state       <= S_DATA;
                        o_Tx_Serial <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state       <= S_STOP;
                            o_Tx_Serial <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_Tx_Serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg   <= head_byte;
                            state       <= S_START;
                            o_Tx_Serial <= 1'b0;
                        end else begin
                            state       <= S_IDLE;
                            o_Tx_Active <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mem.sv
// Self-checking bench for uart_tx_mem: directed scenarios plus random traffic,
// compared every cycle against a frame-timeline model built from queues and cycle counts.
module tb_uart_tx_mem;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic o_Tx_Serial;
    logic o_Tx_Active;
    logic o_Tx_Done;

    uart_tx_mem_if bus ();

    uart_tx_mem #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Done   (o_Tx_Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: bytes waiting, cycles left in the current frame, and the register image.
    logic [7:0] pending[$];
    int         rem = 0;
    logic [7:0] cur_byte = '0;
    logic [7:0] m_last = '0;
    logic       m_over = 1'b0;
    logic       m_done = 1'b0;

    int cycle = 0;
    int done_pulses = 0;
    int done_cycles[$];

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic expSerial();
        int pos, b;
        if (rem == 0) return 1'b1;
        pos = 10 * CPB - rem;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur_byte[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] expRdata();
        logic busy, full;
        busy = (rem > 0) || (pending.size() > 0);
        full = (pending.size() >= CAP);
        return {busy, full, m_over, m_done, 20'd0, m_last};
    endfunction

    task automatic checkOutput();
        checkOne("serial", {31'd0, o_Tx_Serial}, {31'd0, expSerial()});
        checkOne("active", {31'd0, o_Tx_Active}, {31'd0, rem > 0});
        checkOne("done",   {31'd0, o_Tx_Done},   {31'd0, rem == 1});
        checkOne("rdata",  bus.mem_rdata, expRdata());
    endtask

    task automatic modelReset();
        pending.delete();
        rem      = 0;
        cur_byte = '0;
        m_last   = '0;
        m_over   = 1'b0;
        m_done   = 1'b0;
    endtask

    // One clock edge with the given bus write, then model update and full output check.
    task automatic applyStimulus(input logic wen, input logic [31:0] wdata);
        bit full_pre, set_done, do_pop, start, clr;
        bus.mem_wen   = wen;
        bus.mem_wdata = wdata;
        @(posedge clk);
        cycle++;
        full_pre = (pending.size() >= CAP);
        set_done = (rem == 1);
        if (rem > 0) rem--;
        do_pop = (rem == 0) && (pending.size() > 0);
        start  = wen && wdata[31];
        clr    = wen && wdata[30];
        if (clr) begin
            m_over = 1'b0;
            m_done = 1'b0;
        end
        if (set_done) m_done = 1'b1;
        if (start && full_pre) m_over = 1'b1;
        if (do_pop) begin
            cur_byte = pending.pop_front();
            rem      = 10 * CPB;
        end
        if (start && !full_pre) begin
            pending.push_back(wdata[7:0]);
            m_last = wdata[7:0];
        end
        #1;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = $urandom;
        if (o_Tx_Done) begin
            done_pulses++;
            done_cycles.push_back(cycle);
        end
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (((rem > 0) || (pending.size() > 0)) && guard < 3000) begin
            applyStimulus(1'b0, 32'h0);
            guard++;
        end
        checkOne("drain_bound", {31'd0, guard < 3000}, 32'd1);
        idle(2);
    endtask

    initial begin
        int t0;
        int guard;
        int first_done;
        int pulses0;
        logic [7:0] b;
        logic [31:0] w;

        // Reset state
        rst_n         = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = 32'h0;
        modelReset();
        #12;
        checkOutput();
        rst_n = 1'b1;
        idle(3);

        // Single frame 0xA5: done pulse ends at edge N+41
        applyStimulus(1'b1, 32'h8000_00A5);
        t0 = cycle;
        done_cycles.delete();
        idle(45);
        first_done = (done_cycles.size() > 0) ? done_cycles[0] - t0 : -1;
        checkOne("a5_done_latency", first_done, 32'd40);
        checkOne("a5_readback", bus.mem_rdata, 32'h1000_00A5);

        // Clear DONE
        applyStimulus(1'b1, 32'h4000_0000);
        checkOne("clear_bits", {30'd0, bus.mem_rdata[29:28]}, 32'd0);

        // Back-to-back frames
        done_cycles.delete();
        applyStimulus(1'b1, 32'h8000_0055);
        idle(5);
        applyStimulus(1'b1, 32'h8000_000F);
        idle(90);
        checkOne("b2b_pulses", done_cycles.size(), 32'd2);
        if (done_cycles.size() == 2)
            checkOne("b2b_spacing", done_cycles[1] - done_cycles[0], 32'd40);
        applyStimulus(1'b1, 32'h4000_0000);

        // Overrun
`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 32'h8000_0011 + i);
        checkOne("ovr_last", {24'd0, bus.mem_rdata[7:0]}, 32'h11 + DEPTH);
`else
        applyStimulus(1'b1, 32'h8000_0011);
        idle(1);
        applyStimulus(1'b1, 32'h8000_0022);
        applyStimulus(1'b1, 32'h8000_0033);
        checkOne("ovr_last", {24'd0, bus.mem_rdata[7:0]}, 32'h22);
`endif
        checkOne("ovr_flag", {31'd0, bus.mem_rdata[29]}, 32'd1);

        // CLEAR in the same cycle as o_Tx_Done: DONE stays set, OVERRUN clears
        guard = 0;
        while (rem != 1 && guard < 200) begin
            applyStimulus(1'b0, 32'h0);
            guard++;
        end
        checkOne("done_wait_bound", {31'd0, guard < 200}, 32'd1);
        applyStimulus(1'b1, 32'h4000_0000);
        checkOne("clr_vs_done", {30'd0, bus.mem_rdata[29:28]}, 32'h1);
        drain();
        applyStimulus(1'b1, 32'h4000_0000);
        checkOne("clear_again", {30'd0, bus.mem_rdata[29:28]}, 32'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 12));
            w = $urandom;
            w[31] = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b1, w);
        end
        drain();

        // Reset during the data bits
        applyStimulus(1'b1, 32'h8000_00C3);
        idle(15);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOne("rst_serial", {31'd0, o_Tx_Serial}, 32'd1);
        checkOne("rst_rdata", bus.mem_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkOutput();
        applyStimulus(1'b1, 32'h8000_003C);
        drain();

        // Buffer wrap: write whenever there is room; nothing may be dropped
        applyStimulus(1'b1, 32'h4000_0000);
        pulses0 = done_pulses;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            guard = 0;
            while (pending.size() >= CAP && guard < 200) begin
                applyStimulus(1'b0, 32'h0);
                guard++;
            end
            b = 8'($urandom);
            applyStimulus(1'b1, {8'h80, 16'h0, b});
        end
        drain();
        checkOne("wrap_no_overrun", {31'd0, bus.mem_rdata[29]}, 32'd0);
        checkOne("wrap_frames", done_pulses - pulses0, 2 * DEPTH + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end
endmodule
